// File: rtl/cic_input_formatter_if.sv
// Stream bundle for the CIC input formatter: upstream sample handshake,
// downstream widened-sample handshake and the sticky configuration flag.
interface cic_input_formatter_if #(
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 42,
    parameter int PHASE_WIDTH = 3
);
    logic [IN_WIDTH-1:0]    data_in;
    logic                   valid_in;
    logic [3:0]             gain_shift;
    logic                   ready_out;
    logic [ACC_WIDTH-1:0]   data_out;
    logic [PHASE_WIDTH-1:0] phase_out;
    logic                   last_out;
    logic                   valid_out;
    logic                   ready_in;
    logic                   cfg_err;

    // Source/sink side (drives samples in, consumes widened samples)
    modport master (
        output data_in, valid_in, gain_shift, ready_in,
        input  ready_out, data_out, phase_out, last_out, valid_out, cfg_err
    );

    // Formatter side
    modport slave (
        input  data_in, valid_in, gain_shift, ready_in,
        output ready_out, data_out, phase_out, last_out, valid_out, cfg_err
    );
endinterface

// File: rtl/cic_input_formatter.sv
// CIC ingress stage: widens signed Q1.15 samples into the accumulator format,
// applies a clamped power-of-two pre-gain, tags each sample with its decimation
// phase and buffers up to two samples between the source and the integrators.
module cic_input_formatter #(
    parameter int IN_WIDTH   = 16,
    parameter int IN_FRAC    = 15,
    parameter int ACC_WIDTH  = 42,
    parameter int ACC_FRAC   = 32,
    parameter int DEC_FACTOR = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    cic_input_formatter_if.slave    bus
);
    localparam int FRAC_SHIFT = ACC_FRAC - IN_FRAC;
    localparam int GUARD_BITS = (ACC_WIDTH - ACC_FRAC) - (IN_WIDTH - IN_FRAC);
    localparam int PHASE_W    = $clog2(DEC_FACTOR);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DEC_FACTOR - 1);

    generate
        if (FRAC_SHIFT < 0) begin : g_bad_frac
            $error("cic_input_formatter: accumulator has fewer fractional bits than input");
        end
        if (GUARD_BITS < 0) begin : g_bad_guard
            $error("cic_input_formatter: accumulator has fewer integer bits than input");
        end
        if (DEC_FACTOR < 2) begin : g_bad_dec
            $error("cic_input_formatter: decimation factor must be at least 2");
        end
    endgenerate

    logic [1:0]                count;
    logic [ACC_WIDTH-1:0]      head_data;
    logic [ACC_WIDTH-1:0]      skid_data;
    logic [PHASE_W-1:0]        head_phase;
    logic [PHASE_W-1:0]        skid_phase;
    logic [PHASE_W-1:0]        phase_cnt;
    logic                      cfg_err_q;

    logic                      accept;
    logic                      deliver;
    logic                      over_gain;
    logic [4:0]                eff_shift;
    logic [7:0]                shift_amt;
    logic signed [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0]      widened;

    // Handshake decode; ready_out depends only on registered occupancy and rst
    assign bus.ready_out = (count != 2'd2) && !rst;
    assign bus.valid_out = (count != 2'd0);
    assign accept        = bus.valid_in && bus.ready_out;
    assign deliver       = bus.valid_out && bus.ready_in;

    // Exact widening: sign extend, then shift into the accumulator fraction plus gain
    always_comb begin
        over_gain = int'(bus.gain_shift) > GUARD_BITS;
        eff_shift = over_gain ? 5'(GUARD_BITS) : {1'b0, bus.gain_shift};
        shift_amt = 8'(FRAC_SHIFT) + {3'b000, eff_shift};
        ext       = ACC_WIDTH'($signed(bus.data_in));
        widened   = ext <<< shift_amt;
    end

    // Two-entry elastic buffer, phase counter and sticky gain-clamp flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            head_data  <= '0;
            skid_data  <= '0;
            head_phase <= '0;
            skid_phase <= '0;
            phase_cnt  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                phase_cnt <= (phase_cnt == LAST_PHASE) ? '0 : phase_cnt + 1'b1;
                if (over_gain) begin
                    cfg_err_q <= 1'b1;
                end
            end

            case ({accept, deliver})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data  <= widened;
                        head_phase <= phase_cnt;
                    end else begin
                        skid_data  <= widened;
                        skid_phase <= phase_cnt;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Head keeps its value when the buffer empties so outputs hold
                    if (count == 2'd2) begin
                        head_data  <= skid_data;
                        head_phase <= skid_phase;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_data  <= skid_data;
                        head_phase <= skid_phase;
                        skid_data  <= widened;
                        skid_phase <= phase_cnt;
                    end else begin
                        head_data  <= widened;
                        head_phase <= phase_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.data_out  = head_data;
    assign bus.phase_out = head_phase;
    assign bus.last_out  = (head_phase == LAST_PHASE);
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: doc/cic_input_formatter.md
# cic_input_formatter

Ingress stage of the CIC datapath and the mirror of the accumulator-to-output rounding/saturation stage: it takes signed Q1.15 samples and widens them exactly into the CIC accumulator format, Q(ACC_WIDTH−ACC_FRAC).ACC_FRAC. It applies an optional power-of-two pre-gain bounded by the available guard bits and tags each sample with its decimation phase. A 2-entry elastic buffer with valid/ready handshakes on both sides decouples the upstream source from the integrator chain.

## Interface
Parameters:
- IN_WIDTH, 16, input sample width (signed)
- IN_FRAC, 15, input fractional bits
- ACC_WIDTH, 42, output/accumulator width (signed)
- ACC_FRAC, 32, accumulator fractional bits
- DEC_FACTOR, 5, decimation ratio; phase counter modulus (≥2)
- Derived: FRAC_SHIFT = ACC_FRAC−IN_FRAC (17); GUARD_BITS = (ACC_WIDTH−ACC_FRAC)−(IN_WIDTH−IN_FRAC) (9). Elaboration error if FRAC_SHIFT<0 or GUARD_BITS<0.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  IN_WIDTH  signed Q1.15 sample
- valid_in  in  1  upstream sample valid
- gain_shift  in  4  left-shift pre-gain, sampled with each accepted sample
- ready_out  out  1  block can accept a sample
- data_out  out  ACC_WIDTH  signed widened sample
- phase_out  out  $clog2(DEC_FACTOR)  decimation phase of data_out
- last_out  out  1  data_out is phase DEC_FACTOR−1
- valid_out  out  1  data_out/phase_out/last_out valid
- ready_in  in  1  downstream accepts
- cfg_err  out  1  sticky: a gain_shift > GUARD_BITS was accepted

## Operation
- Accept: valid_in && ready_out on a rising edge. Deliver: valid_out && ready_in.
- Effective shift s = min(gain_shift, GUARD_BITS); if gain_shift > GUARD_BITS on an accepted sample, set cfg_err (cleared only by rst).
- Widening: data_out = sign_extend(data_in, ACC_WIDTH) <<< (FRAC_SHIFT + s). Exact, no rounding; cannot overflow because s ≤ GUARD_BITS. −1.0 at s=GUARD_BITS gives −2^(ACC_WIDTH−1).
- Phase counter: 0..DEC_FACTOR−1, increments on every accept, wraps to 0 after DEC_FACTOR−1. Phase is captured with the sample and travels with it; last_out = (phase == DEC_FACTOR−1).
- Buffer: 2 entries (head register driving the outputs, plus a skid register), FIFO order, occupancy count 0..2.
  - ready_out = (count != 2) && !rst, decoded from registered count only (no combinational path from ready_in).
  - Accept and deliver in the same cycle: count unchanged, skid moves to head if occupied, the new entry fills the freed slot.
  - count 0: valid_out=0; data_out, phase_out and last_out hold their last values (no X).
- Upstream data is not checked while valid_in=0. gain_shift is ignored unless accepting.

## Timing
- Latency: a sample accepted at edge N appears on valid_out/data_out after edge N (1 cycle) when the buffer was empty.
- Throughput: 1 sample/cycle while ready_in=1.
- Backpressure: with ready_in=0, two samples are absorbed, then ready_out falls in the cycle after the second accept. ready_out rises in the cycle after the first deliver.
- valid_out, once high, stays high with stable data_out/phase_out until delivered.
- Reset (sync, any cycle including mid-stream): next edge sets count=0, phase counter=0, cfg_err=0, valid_out=0, data_out=0, phase_out=0, last_out=0. Buffered samples are discarded. ready_out=0 while rst=1 and 1 in the first cycle after rst falls.

## Test plan
- Basic widening: data_in=0x4000, gain_shift=0 → data_out=0x000_8000_0000 (2^31), phase_out=0, 1-cycle latency, cfg_err=0.
- Max gain, negative full scale: data_in=0x8000, gain_shift=9 → data_out=0x200_0000_0000 (−2^41). data_in=0x7FFF, gain_shift=9 → 0x1FF_FC00_0000.
- Gain clamp: gain_shift=12 with data_in=0x0001 → data_out=0x000_0400_0000 (shift 26), cfg_err=1 and stays set across later valid shifts.
- Phase wrap: 12 back-to-back samples with ready_in=1 → phase_out 0,1,2,3,4,0,…,1; last_out high on the 5th and 10th samples.
- Backpressure: ready_in=0 while sending 3 samples → 2 accepted, ready_out low, 3rd held upstream. Release ready_in → order preserved, no loss or duplication, continuous 1/cycle.
- Mid-stream reset: rst pulsed with count=2 → all outputs 0, phase restarts at 0 on the next accepted sample, cfg_err cleared.
